fixed_self_att_fork: RTL and testbench

Parametrised eager fork for the attention input path. It replaces the lazy three-way valid/ready join in front of the Q/K/V projections with NUM_BRANCH independent output channels. Each channel may accept a beat in a different cycle. A runtime branch-enable mask selects which channels receive each block, which supports cross-attention and K/V-only reuse. A beat counter marks the last beat of each IN_NUM_PARALLELISM × IN_DEPTH block.

---
 rtl/fixed_att_pkg.sv | 19 +
 rtl/fixed_self_att_skid.sv | 57 +++++
 rtl/fixed_self_att_fork.sv | 99 +++++++++
 tb/tb_fixed_self_att_fork.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_att_pkg.sv
// Shared constants and sizing helpers for the attention-input fork.
package fixed_att_pkg;

    // Default channel order of the fork outputs
    localparam int BR_Q = 0;
    localparam int BR_K = 1;
    localparam int BR_V = 2;

    // Beats making up one IN_NUM_PARALLELISM x IN_DEPTH block
    function automatic int calc_beats(input int num_par, input int depth);
        return num_par * depth;
    endfunction

    // Beat counter width; never narrower than one bit
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fixed_self_att_skid.sv
// One-channel 2-entry skid buffer (payload + last flag). Output is registered
// and the upstream ready is a register, so no ready path crosses this stage.
module fixed_self_att_skid
    import fixed_att_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ELEMS      = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [ELEMS-1:0][DATA_WIDTH-1:0] i_data,
    input  logic                             i_last,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [ELEMS-1:0][DATA_WIDTH-1:0] o_data,
    output logic                             o_last
);
    localparam int PW = ELEMS * DATA_WIDTH + 1;

    logic          r_vld;
    logic          r_svld;
    logic [PW-1:0] r_main;
    logic [PW-1:0] r_skid;
    logic [PW-1:0] w_in;

    assign w_in    = {i_last, i_data};
    assign o_ready = ~r_svld;
    assign o_valid = r_vld;
    assign o_data  = r_main[PW-2:0];
    assign o_last  = r_main[PW-1];

    // Main register refills from the skid entry first, else from the input;
    // when the main register is stalled a new beat parks in the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_svld <= 1'b0;
            r_main <= '0;
            r_skid <= '0;
        end else if (!r_vld || i_ready) begin
            if (r_svld) begin
                r_main <= r_skid;
                r_vld  <= 1'b1;
                r_svld <= 1'b0;
            end else begin
                r_vld <= i_valid;
                if (i_valid) r_main <= w_in;
            end
        end else if (i_valid && !r_svld) begin
            r_skid <= w_in;
            r_svld <= 1'b1;
        end
    end

endmodule

// File: rtl/fixed_self_att_fork.sv
// Eager NUM_BRANCH-way fork for the Q/K/V input path with per-block branch
// mask and last-beat-of-block flag.
// Optional FIXED_SELF_ATT_FORK_SKID_EN: registered 2-entry skid per channel.
module fixed_self_att_fork
    import fixed_att_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int IN_PARALLELISM     = 3,
    parameter int IN_SIZE            = 3,
    parameter int IN_NUM_PARALLELISM = 2,
    parameter int IN_DEPTH           = 3,
    parameter int NUM_BRANCH         = 3
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [IN_PARALLELISM*IN_SIZE-1:0][DATA_WIDTH-1:0]     data_in,
    input  logic                                                  data_in_valid,
    output logic                                                  data_in_ready,
    input  logic [NUM_BRANCH-1:0]                                 branch_en,
    output logic [NUM_BRANCH*IN_PARALLELISM*IN_SIZE-1:0][DATA_WIDTH-1:0] data_out,
    output logic [NUM_BRANCH-1:0]                                 data_out_valid,
    input  logic [NUM_BRANCH-1:0]                                 data_out_ready,
    output logic [NUM_BRANCH-1:0]                                 data_out_last
);
    localparam int            ELEMS    = IN_PARALLELISM * IN_SIZE;
    localparam int            BEATS    = calc_beats(IN_NUM_PARALLELISM, IN_DEPTH);
    localparam int            CW       = cnt_width(BEATS);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    logic [CW-1:0]         r_cnt;
    logic [NUM_BRANCH-1:0] r_mask;
    logic [NUM_BRANCH-1:0] r_taken;
    logic [NUM_BRANCH-1:0] w_eff;
    logic [NUM_BRANCH-1:0] w_fvld;
    logic [NUM_BRANCH-1:0] w_frdy;
    logic                  w_first;
    logic                  w_last;
    logic                  w_all_done;
    logic                  w_consume;

    // Fork handshake: live branch_en only until the first channel of a block
    // takes beat 0, latched mask afterwards.
    always_comb begin
        w_first    = (r_cnt == '0) && (r_taken == '0);
        w_eff      = w_first ? branch_en : r_mask;
        w_fvld     = rst ? '0 : ({NUM_BRANCH{data_in_valid}} & w_eff & ~r_taken);
        w_all_done = &(~w_eff | r_taken | w_frdy);
        w_last     = (r_cnt == LAST_CNT);
        w_consume  = data_in_valid && w_all_done && !rst;
    end

    assign data_in_ready = rst ? ~|w_eff : w_all_done;

    // Beat counter, mask latch and per-channel taken flags. The mask tracks
    // branch_en for as long as eff is still sourced from it, so a beat 0 that
    // is split over several cycles keeps the mask it started with.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_mask  <= '1;
            r_taken <= '0;
        end else begin
            if (w_first) r_mask <= branch_en;
            if (w_consume) begin
                r_taken <= '0;
                r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
            end else begin
                r_taken <= r_taken | (w_fvld & w_frdy);
            end
        end
    end

    for (genvar b = 0; b < NUM_BRANCH; b++) begin : g_ch
`ifdef FIXED_SELF_ATT_FORK_SKID_EN
        fixed_self_att_skid #(
            .DATA_WIDTH(DATA_WIDTH),
            .ELEMS     (ELEMS)
        ) u_skid (
            .clk    (clk),
            .rst    (rst),
            .i_valid(w_fvld[b]),
            .o_ready(w_frdy[b]),
            .i_data (data_in),
            .i_last (w_last),
            .o_valid(data_out_valid[b]),
            .i_ready(data_out_ready[b]),
            .o_data (data_out[b*ELEMS +: ELEMS]),
            .o_last (data_out_last[b])
        );
`else
        // Pass-through; payload and last are zeroed whenever the channel is idle
        assign data_out_valid[b]          = w_fvld[b];
        assign w_frdy[b]                  = data_out_ready[b];
        assign data_out[b*ELEMS +: ELEMS] = w_fvld[b] ? data_in : '0;
        assign data_out_last[b]           = w_fvld[b] & w_last;
`endif
    end

endmodule

// File: tb/tb_fixed_self_att_fork.sv
// Scoreboard bench for fixed_self_att_fork: driver pushes expected beats per
// channel at issue time, a negedge monitor pops on every output handshake.
module tb_fixed_self_att_fork;
    import fixed_att_pkg::*;

    localparam int DW = 8, P = 3, S = 3, NP = 2, D = 3, NB = 3;
    localparam int ELEMS = P * S;
    localparam int EW    = ELEMS * DW;
    localparam int BEATS = NP * D;

    typedef struct packed {
        logic [EW-1:0] d;
        logic          last;
    } exp_t;

    logic                            clk, rst;
    logic [ELEMS-1:0][DW-1:0]        data_in;
    logic                            data_in_valid, data_in_ready;
    logic [NB-1:0]                   branch_en;
    logic [NB*ELEMS-1:0][DW-1:0]     data_out;
    logic [NB-1:0]                   data_out_valid, data_out_ready, data_out_last;

    fixed_self_att_fork #(
        .DATA_WIDTH(DW), .IN_PARALLELISM(P), .IN_SIZE(S),
        .IN_NUM_PARALLELISM(NP), .IN_DEPTH(D), .NUM_BRANCH(NB)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .branch_en(branch_en), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_last(data_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_fail = 0;
    exp_t q [NB][$];

    task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [NB-1:0]            prev_stall = '0;
    logic [EW-1:0]            prev_d [NB];
    logic                     prev_l [NB];
    logic [ELEMS-1:0][DW-1:0] mon_sl;
    exp_t                     mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                mon_sl = data_out[b*ELEMS +: ELEMS];
                if (prev_stall[b]) begin
                    check(data_out_valid[b] && (mon_sl == prev_d[b]) && (data_out_last[b] == prev_l[b]),
                          $sformatf("hold_ch%0d", b), 128'(mon_sl), 128'(prev_d[b]));
                end
                if (data_out_valid[b] && data_out_ready[b]) begin
                    if (q[b].size() == 0) begin
                        check(1'b0, $sformatf("unexpected_beat_ch%0d", b), 128'(mon_sl), 128'(0));
                    end else begin
                        mon_e = q[b].pop_front();
                        check(mon_sl == mon_e.d, $sformatf("payload_ch%0d", b), 128'(mon_sl), 128'(mon_e.d));
                        check(data_out_last[b] == mon_e.last, $sformatf("last_ch%0d", b),
                              128'(data_out_last[b]), 128'(mon_e.last));
                    end
                end
                prev_stall[b] = data_out_valid[b] & ~data_out_ready[b];
                prev_d[b]     = mon_sl;
                prev_l[b]     = data_out_last[b];
            end
        end
    end

    // ---------------- driver + reference model ----------------
    int            k = 0;          // beat index within the current block
    logic [NB-1:0] blk_mask = '1;  // mask the reference model applies to this block
    bit            rnd_rdy = 0;
    int            hold_k = 0;     // cycles K ready is forced low

    function automatic logic [EW-1:0] rand_d();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[EW-1:0];
    endfunction

    task automatic upd_ready();
        if (rnd_rdy) begin
            data_out_ready = NB'($urandom());
        end else if (hold_k > 0) begin
            data_out_ready = '1;
            data_out_ready[BR_K] = 1'b0;
            hold_k--;
        end else begin
            data_out_ready = '1;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        upd_ready();
    endtask

    // Present a beat and record what each enabled channel must receive
    task automatic issue(input logic [EW-1:0] d, input logic [NB-1:0] en);
        exp_t e;
        data_in       = d;
        branch_en     = en;
        data_in_valid = 1'b1;
        if (k == 0) blk_mask = en;
        e.d    = d;
        e.last = (k == BEATS - 1);
        for (int b = 0; b < NB; b++)
            if (blk_mask[b]) q[b].push_back(e);
    endtask

    task automatic retire();
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        k = (k + 1) % BEATS;
        upd_ready();
    endtask

    task automatic send_beat(input logic [EW-1:0] d, input logic [NB-1:0] en);
        int n;
        issue(d, en);
        upd_ready();
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (data_in_ready) break;
            @(posedge clk); #1;
            upd_ready();
        end
        if (n >= 200) check(1'b0, "in_ready_timeout", 128'(0), 128'(1));
        retire();
    endtask

    task automatic drain();
        rnd_rdy = 0;
        hold_k  = 0;
        data_out_ready = '1;
        repeat (10) tick();
        for (int b = 0; b < NB; b++)
            check(q[b].size() == 0, $sformatf("drain_empty_ch%0d", b), 128'(q[b].size()), 128'(0));
    endtask

    task automatic reset_checks();
        @(negedge clk);
        check(data_out_valid == '0, "rst_valid", 128'(data_out_valid), 128'(0));
        check(data_out_last == '0, "rst_last", 128'(data_out_last), 128'(0));
        check(data_out == '0, "rst_data", 128'(data_out), 128'(0));
        check(data_in_ready == 1'b0, "rst_in_ready_en", 128'(data_in_ready), 128'(0));
        @(posedge clk); #1;
        branch_en = '0;
        @(negedge clk);
        check(data_in_ready == 1'b1, "rst_in_ready_masked", 128'(data_in_ready), 128'(1));
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        data_in = '0;
        data_in_valid = 1'b0;
        branch_en = '1;
        data_out_ready = '1;
        repeat (2) @(posedge clk);
        reset_checks();
        @(posedge clk); #1;
        rst = 1'b0;
        branch_en = '1;
        tick();

        // Full throughput: two blocks, payload = beat index
        t0 = cyc;
        for (int i = 0; i < 2 * BEATS; i++) send_beat(EW'(i), 3'b111);
        check((cyc - t0) == 2 * BEATS, "throughput_cycles", 128'(cyc - t0), 128'(2 * BEATS));
        drain();

        // Staggered ready on beat 0: Q, then V, then K
`ifndef FIXED_SELF_ATT_FORK_SKID_EN
        issue(rand_d(), 3'b111);
        data_out_ready = 3'b001;
        @(negedge clk);
        check(data_in_ready == 1'b0, "stagger_rdy_c0", 128'(data_in_ready), 128'(0));
        @(posedge clk); #1;
        data_out_ready = 3'b100;
        @(negedge clk);
        check(data_in_ready == 1'b0, "stagger_rdy_c1", 128'(data_in_ready), 128'(0));
        @(posedge clk); #1;
        data_out_ready = 3'b010;
        @(negedge clk);
        check(data_in_ready == 1'b1, "stagger_rdy_c2", 128'(data_in_ready), 128'(1));
        retire();
`else
        send_beat(rand_d(), 3'b111);
`endif
        for (int i = 1; i < BEATS; i++) send_beat(rand_d(), 3'b111);
        drain();

        // Mask latch: switching branch_en mid-block has no effect
        for (int i = 0; i < BEATS; i++) send_beat(rand_d(), (i < 3) ? 3'b110 : 3'b111);
        for (int i = 0; i < BEATS; i++) send_beat(rand_d(), 3'b111);
        drain();

        // All-zero mask: one beat per cycle, nothing delivered
        t0 = cyc;
        for (int i = 0; i < BEATS; i++) send_beat(rand_d(), 3'b000);
        check((cyc - t0) == BEATS, "zero_mask_cycles", 128'(cyc - t0), 128'(BEATS));
        for (int i = 0; i < BEATS; i++) send_beat(rand_d(), 3'b111);
        drain();

        // Backpressure: K held off for 5 cycles on beat 4
        for (int i = 0; i < 4; i++) send_beat(rand_d(), 3'b111);
        hold_k = 5;
        t0 = cyc;
        send_beat(rand_d(), 3'b111);
`ifndef FIXED_SELF_ATT_FORK_SKID_EN
        check((cyc - t0) == 6, "bp_beat4_cycles", 128'(cyc - t0), 128'(6));
`endif
        send_beat(rand_d(), 3'b111);
        drain();

        // Reset mid-block after Q took beat 2
        send_beat(rand_d(), 3'b111);
        send_beat(rand_d(), 3'b111);
        issue(rand_d(), 3'b111);
        data_out_ready = 3'b001;
        @(negedge clk);
`ifndef FIXED_SELF_ATT_FORK_SKID_EN
        check(data_in_ready == 1'b0, "mid_rst_partial", 128'(data_in_ready), 128'(0));
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        data_in_valid = 1'b0;
        for (int b = 0; b < NB; b++) q[b].delete();
        k = 0;
        @(posedge clk);
        reset_checks();
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        for (int i = 0; i < BEATS; i++) send_beat(rand_d(), 3'b111);
        drain();

        // Randomized blocks: random masks, mid-block mask noise, random readies and gaps
        rnd_rdy = 1;
        for (int blk = 0; blk < 25; blk++) begin
            for (int i = 0; i < BEATS; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send_beat(rand_d(), NB'($urandom()));
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
